// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed from a small TX FIFO.
//
// Bytes pushed into the FIFO are framed onto uart_txd. Frames that are
// already queued go out back-to-back. Each frame has a start bit, 5-8 data
// bits sent LSB first, an optional even/odd parity bit and 1 or 2 stop bits.
// The bit period and the frame format are sampled when an entry is popped.
// A later change therefore only affects the next frame.
//
// Ports:
//   clk, rst_n         clock; synchronous active-low reset
//   wr_bit_period_i    load strobe for bit_period_i (cycles per bit minus 1)
//   data_bits_i        00=5, 01=6, 10=7, 11=8 data bits
//   parity_mode_i      00/11=none, 01=even, 10=odd
//   stop_bits_i        0=one stop bit, 1=two stop bits
//   tx_valid_i/tx_data_i/tx_ready_o   FIFO push handshake
//   fifo_count_o, fifo_empty_o        FIFO occupancy
//   uart_txd           serial line, idles high
//   uart_tx_busy       frame in progress or data still queued
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | line high, waiting for a FIFO entry
// S_START  | start bit (low)
// S_DATA   | data bits, LSB first
// S_PARITY | parity bit, only when parity is enabled
// S_STOP   | stop bit(s) (high); pops the next entry on the last cycle

module uart_tx_fifo #(
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 50000000,
  parameter int FIFO_DEPTH = 8,
  parameter int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_bit_period_i,
  input  logic [15:0]   bit_period_i,
  input  logic [1:0]    data_bits_i,
  input  logic [1:0]    parity_mode_i,
  input  logic          stop_bits_i,
  input  logic          tx_valid_i,
  input  logic [7:0]    tx_data_i,
  output logic          tx_ready_o,
  output logic [CW-1:0] fifo_count_o,
  output logic          fifo_empty_o,
  output logic          uart_txd,
  output logic          uart_tx_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DEF_BP_I = CLK_FREQ / BAUD_RATE - 1;
  localparam logic [15:0] DEF_BP = DEF_BP_I[15:0];
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [15:0]   r_bit_period;

  state_t        r_state;
  logic [15:0]   r_cnt;
  logic [15:0]   r_bp_l;
  logic [7:0]    r_data;
  logic [1:0]    r_nbits;
  logic          r_par_en;
  logic          r_par_bit;
  logic          r_two_stop;
  logic          r_stop_left;
  logic [2:0]    r_bit_idx;
  logic          r_txd;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_bit_end;
  logic          w_frame_end;
  logic [7:0]    w_head;
  logic [7:0]    w_mask;
  logic          w_par_even;
  logic          w_par_bit;
  logic          w_par_en;
  logic [2:0]    w_last_idx;
  logic [2:0]    w_next_idx;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  // A push against a full FIFO is dropped even when a pop frees a slot
  // on the same edge; ready only reflects the registered count.
  assign w_push  = tx_valid_i && !w_full;

  assign w_bit_end   = (r_cnt == 16'd0);
  assign w_frame_end = (r_state == S_STOP) && w_bit_end && !r_stop_left;
  assign w_pop       = !w_empty && ((r_state == S_IDLE) || w_frame_end);

  // Parity is computed from the head entry at pop time, so only the
  // configured number of data bits is included.
  assign w_head     = r_mem[r_rd_ptr];
  assign w_mask     = 8'hFF >> (2'd3 - data_bits_i);
  assign w_par_even = ^(w_head & w_mask);
  assign w_par_bit  = (parity_mode_i == 2'b10) ? ~w_par_even : w_par_even;
  assign w_par_en   = (parity_mode_i == 2'b01) || (parity_mode_i == 2'b10);

  assign w_last_idx = 3'd4 + {1'b0, r_nbits};
  assign w_next_idx = r_bit_idx + 3'd1;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= tx_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bit_period <= DEF_BP;
    end else if (wr_bit_period_i) begin
      r_bit_period <= bit_period_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_txd       <= 1'b1;
      r_cnt       <= 16'd0;
      r_bp_l      <= DEF_BP;
      r_data      <= 8'd0;
      r_nbits     <= 2'd0;
      r_par_en    <= 1'b0;
      r_par_bit   <= 1'b0;
      r_two_stop  <= 1'b0;
      r_stop_left <= 1'b0;
      r_bit_idx   <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_txd <= 1'b1;
        end
        S_START: begin
          if (w_bit_end) begin
            r_state   <= S_DATA;
            r_bit_idx <= 3'd0;
            r_txd     <= r_data[0];
            r_cnt     <= r_bp_l;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_cnt <= r_bp_l;
            if (r_bit_idx == w_last_idx) begin
              if (r_par_en) begin
                r_state <= S_PARITY;
                r_txd   <= r_par_bit;
              end else begin
                r_state     <= S_STOP;
                r_txd       <= 1'b1;
                r_stop_left <= r_two_stop;
              end
            end else begin
              r_bit_idx <= w_next_idx;
              r_txd     <= r_data[w_next_idx];
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_state     <= S_STOP;
            r_txd       <= 1'b1;
            r_stop_left <= r_two_stop;
            r_cnt       <= r_bp_l;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            if (r_stop_left) begin
              r_stop_left <= 1'b0;
              r_cnt       <= r_bp_l;
            end else begin
              r_state <= S_IDLE;
              r_txd   <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_txd   <= 1'b1;
        end
      endcase

      // A pop only happens from IDLE or on the final stop-bit cycle, so it
      // overrides whatever the case above chose and starts the next frame
      // without an idle cycle.
      if (w_pop) begin
        r_state    <= S_START;
        r_txd      <= 1'b0;
        r_cnt      <= r_bit_period;
        r_bp_l     <= r_bit_period;
        r_data     <= w_head;
        r_nbits    <= data_bits_i;
        r_par_en   <= w_par_en;
        r_par_bit  <= w_par_bit;
        r_two_stop <= stop_bits_i;
      end
    end
  end

  assign tx_ready_o   = !w_full;
  assign fifo_count_o = r_count;
  assign fifo_empty_o = w_empty;
  assign uart_txd     = r_txd;
  assign uart_tx_busy = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
module tb_uart_tx_fifo;
  localparam int FIFO_DEPTH = 8;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_bit_period_i = 1'b0;
  logic [15:0]   bit_period_i = 16'd0;
  logic [1:0]    data_bits_i = 2'b11;
  logic [1:0]    parity_mode_i = 2'b00;
  logic          stop_bits_i = 1'b0;
  logic          tx_valid_i = 1'b0;
  logic [7:0]    tx_data_i = 8'd0;
  logic          tx_ready_o;
  logic [CW-1:0] fifo_count_o;
  logic          fifo_empty_o;
  logic          uart_txd;
  logic          uart_tx_busy;

  uart_tx_fifo #(
    .BAUD_RATE (115200),
    .CLK_FREQ  (50000000),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_bit_period_i(wr_bit_period_i),
    .bit_period_i   (bit_period_i),
    .data_bits_i    (data_bits_i),
    .parity_mode_i  (parity_mode_i),
    .stop_bits_i    (stop_bits_i),
    .tx_valid_i     (tx_valid_i),
    .tx_data_i      (tx_data_i),
    .tx_ready_o     (tx_ready_o),
    .fifo_count_o   (fifo_count_o),
    .fifo_empty_o   (fifo_empty_o),
    .uart_txd       (uart_txd),
    .uart_tx_busy   (uart_tx_busy)
  );

  always #5 clk = ~clk;

  // Expected frame: data, data bits, parity (0 none, 1 even, 2 odd),
  // stop bits, bit period, and idle cycles before it (-1 = not checked).
  typedef struct {
    logic [7:0] data;
    int         nb;
    int         par;
    int         stop;
    int         bp;
    int         gap;
  } frame_t;

  frame_t sb[$];
  int     checks = 0;
  int     failures = 0;
  logic   mon_en = 1'b0;
  logic   mon_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_add(input logic [7:0] d, input int nb, input int par, input int stop,
                        input int bp, input int gap);
    frame_t f;
    f.data = d;
    f.nb   = nb;
    f.par  = par;
    f.stop = stop;
    f.bp   = bp;
    f.gap  = gap;
    sb.push_back(f);
  endtask

  task automatic push(input logic [7:0] d, input int nb, input int par, input int stop,
                      input int bp, input int gap, input bit track);
    tick();
    if (track) begin
      chk($sformatf("push_ready_%02h", d), tx_ready_o, 1);
      sb_add(d, nb, par, stop, bp, gap);
    end
    tx_valid_i = 1'b1;
    tx_data_i  = d;
    tick();
    tx_valid_i = 1'b0;
  endtask

  task automatic wr_bp(input logic [15:0] v);
    tick();
    wr_bit_period_i = 1'b1;
    bit_period_i    = v;
    tick();
    wr_bit_period_i = 1'b0;
  endtask

  task automatic set_cfg(input logic [1:0] db, input logic [1:0] pm, input logic sb2);
    data_bits_i   = db;
    parity_mode_i = pm;
    stop_bits_i   = sb2;
  endtask

  task automatic wait_idle(input string name, input int max);
    int n;
    n = 0;
    while ((sb.size() != 0 || mon_busy || uart_tx_busy) && n < max) begin
      tick();
      n++;
    end
    chk({name, "_drained"}, (n < max), 1);
  endtask

  task automatic busy_len(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (uart_tx_busy && n < 500);
  endtask

  // Monitor: on each start bit pop the next expected frame and check every
  // cycle of every bit, plus the idle gap since the previous frame.
  initial begin : monitor
    frame_t      f;
    logic [11:0] expv;
    logic [11:0] gotv;
    int          nbits;
    int          errs;
    logic        p;
    longint      last_end;
    longint      gap;
    last_end = 0;
    forever begin
      @(negedge clk);
      if (mon_en && uart_txd === 1'b0) begin
        mon_busy = 1'b1;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame: got start bit at %0t, expected idle line", $time);
          while (uart_txd !== 1'b1) @(negedge clk);
        end else begin
          f = sb.pop_front();
          if (f.gap >= 0) begin
            gap = ($time - last_end) / 10 - 1;
            chk($sformatf("gap_%02h", f.data), gap[31:0], f.gap);
          end
          expv = '1;
          expv[0] = 1'b0;
          for (int i = 0; i < f.nb; i++) expv[1+i] = f.data[i];
          nbits = 1 + f.nb;
          if (f.par != 0) begin
            p = 1'b0;
            for (int i = 0; i < f.nb; i++) p = p ^ f.data[i];
            if (f.par == 2) p = ~p;
            expv[nbits] = p;
            nbits++;
          end
          for (int s = 0; s < f.stop; s++) begin
            expv[nbits] = 1'b1;
            nbits++;
          end
          gotv = '1;
          errs = 0;
          for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c <= f.bp; c++) begin
              if (!(b == 0 && c == 0)) @(negedge clk);
              if (c == 0) gotv[b] = uart_txd;
              if (uart_txd !== expv[b]) errs++;
            end
          end
          last_end = $time;
          checks++;
          if (errs != 0 || gotv !== expv) begin
            failures++;
            $display("FAIL frame_%02h: got bits=%03h expected bits=%03h hold_errors=%0d",
                     f.data, gotv, expv, errs);
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_txd", uart_txd, 1);
    chk("rst_busy", uart_tx_busy, 0);
    chk("rst_ready", tx_ready_o, 1);
    chk("rst_count", fifo_count_o, 0);
    chk("rst_empty", fifo_empty_o, 1);
    mon_en = 1'b1;

    // Default bit period: 50e6/115200-1 = 433
    set_cfg(2'b11, 2'b00, 1'b0);
    push(8'h55, 8, 0, 1, 433, -1, 1);
    wait_idle("default_bp", 6000);

    // Reset in the middle of a frame
    mon_en = 1'b0;
    push(8'h00, 8, 0, 1, 433, -1, 0);
    push(8'h11, 8, 0, 1, 433, -1, 0);
    push(8'h22, 8, 0, 1, 433, -1, 0);
    repeat (5) tick();
    chk("pre_rst_txd", uart_txd, 0);
    chk("pre_rst_count", fifo_count_o, 2);
    rst_n = 1'b0;
    tick();
    chk("midrst_txd", uart_txd, 1);
    chk("midrst_count", fifo_count_o, 0);
    chk("midrst_busy", uart_tx_busy, 0);
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;

    // 8N1, bit period 3: latency and busy duration
    wr_bp(16'd3);
    set_cfg(2'b11, 2'b00, 1'b0);
    push(8'hA5, 8, 0, 1, 3, -1, 1);
    chk("lat_k1_txd", uart_txd, 1);
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) chk("lat_k2_txd", uart_txd, 0);
    end while (uart_tx_busy && n < 200);
    chk("busy_len_8n1", n, 41);
    wait_idle("8n1", 200);

    // Parity, bit period 1
    wr_bp(16'd1);
    set_cfg(2'b11, 2'b01, 1'b0);
    push(8'hA5, 8, 1, 1, 1, -1, 1);
    wait_idle("8e1", 200);
    set_cfg(2'b11, 2'b10, 1'b0);
    push(8'hA5, 8, 2, 1, 1, -1, 1);
    wait_idle("8o1", 200);
    set_cfg(2'b10, 2'b10, 1'b1);
    push(8'h41, 7, 2, 2, 1, -1, 1);
    busy_len(n);
    chk("busy_len_7o2", n, 23);
    wait_idle("7o2", 200);

    // Fill the FIFO while a long frame is running
    wr_bp(16'd100);
    set_cfg(2'b11, 2'b00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("fill_ready_%0d", i), tx_ready_o, (i < 9));
      if (i < 9) sb_add(8'h10 + 8'(i), 8, 0, 1, 100, (i == 0) ? -1 : 0);
      tx_valid_i = 1'b1;
      tx_data_i  = 8'h10 + 8'(i);
    end
    tick();
    chk("fill_count", fifo_count_o, 8);
    chk("fill_full_ready", tx_ready_o, 0);
    // Keep pushing while full; the push at the pop edge must be dropped.
    tx_data_i = 8'hEE;
    n = 0;
    while (!tx_ready_o && n < 2000) begin
      tick();
      n++;
    end
    tx_valid_i = 1'b0;
    chk("ready_return", n, 1002);
    chk("count_after_pop", fifo_count_o, 7);
    wait_idle("fill", 12000);

    // Bit period written mid-frame only affects the next frame
    wr_bp(16'd3);
    set_cfg(2'b11, 2'b00, 1'b0);
    push(8'h3C, 8, 0, 1, 3, -1, 1);
    repeat (10) tick();
    wr_bp(16'd9);
    push(8'hC3, 8, 0, 1, 9, 0, 1);
    wait_idle("bp_change", 400);

    // 5N1: upper bits not sent, second frame back-to-back
    set_cfg(2'b00, 2'b00, 1'b0);
    push(8'hFF, 5, 0, 1, 9, -1, 1);
    push(8'h00, 5, 0, 1, 9, 0, 1);
    wait_idle("5n1", 400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
